rv32m_div_unit: RTL and testbench
=================================

# rv32m_div_unit

Multi-cycle RV32M divide/remainder unit in the EX stage, consuming the divide-side decode outputs of the ALU control decoder: `i_ctrl_Start_Div`, `i_ctrl_Unsigned`, and ALU select codes 1100 (quotient) and 1101 (remainder). It computes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle. It stalls the pipeline through `o_Stall` until the result is valid.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.

Ports:
- `i_clk`, input, 1: clock. All state changes on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_ctrl_Start_Div`, input, 1: divide request from the decoder; level, held while the instruction sits in EX.
- `i_ctrl_Unsigned`, input, 1: 1 selects DIVU/REMU, 0 selects DIV/REM.
- `i_ctrl_ALU_Sel`, input, 4: 1100 returns the quotient, 1101 returns the remainder.
- `i_Operand_A`, input, XLEN: dividend (rs1).
- `i_Operand_B`, input, XLEN: divisor (rs2).
- `i_Flush`, input, 1: aborts the operation in flight.
- `o_Result`, output, XLEN: registered quotient or remainder.
- `o_Done`, output, 1: one-cycle pulse; `o_Result` is valid in this cycle.
- `o_Stall`, output, 1: pipeline hold request.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `i_ctrl_Start_Div` is high and `i_Flush` is low, the request is accepted.
  - On acceptance, latch operands, `i_ctrl_Unsigned`, and the rem/quot select.
  - Divisor == 0 → DONE. Result is all-ones (quotient) or the dividend (remainder).
  - Signed, dividend = 0x80000000 and divisor = 0xFFFFFFFF → DONE. Result is 0x80000000 (quotient) or 0 (remainder).
  - Otherwise → CALC with count = 0.
- **Sign handling before CALC**
  - Signed operation: operate on absolute values.
  - Record `neg_q` = sign(A) XOR sign(B).
  - Record `neg_r` = sign(A).
- **CALC**
  - Per cycle: shift the {remainder, quotient} register left by 1.
  - Trial-subtract the divisor from the upper half, using XLEN+1-bit width for the borrow.
  - If no borrow, keep the difference and set quotient bit 0.
  - Count increments; after XLEN iterations → FIX.
- **FIX**
  - Negate the quotient if `neg_q`; negate the remainder if `neg_r` (two's complement, modulo 2^XLEN).
  - Load `o_Result` with the selected value.
  - → DONE.
- **DONE**
  - `o_Done` = 1.
  - → IDLE unconditionally.
- **Input stability**
  - `i_ctrl_Start_Div` is ignored outside IDLE.
  - Operand and control changes after acceptance have no effect.
- **Flush**
  - `i_Flush` high in any state → IDLE on the next edge.
  - No `o_Done`; `o_Result` is unchanged.
  - A flush in the acceptance cycle prevents acceptance.
- **Result hold**
  - `o_Result` holds its value until the next FIX or fast-path load.
- **Stall**
  - `o_Stall` = (IDLE & `i_ctrl_Start_Div` & !`i_Flush`) | CALC | FIX.
  - Combinational from state and inputs; low in DONE.

## Timing
- **Reset**
  - state = IDLE, count = 0, `o_Result` = 0, `o_Done` = 0.
  - `o_Stall` = 0 while `i_ctrl_Start_Div` is low.
- **Reset mid-operation**: returns to IDLE immediately, with no `o_Done` pulse.
- **Normal path** (request accepted in cycle T):
  - CALC runs T+1..T+XLEN; FIX is T+XLEN+1; DONE is T+XLEN+2.
  - For XLEN = 32, `o_Done` = 1 and `o_Stall` = 0 in cycle T+34.
  - `o_Stall` is high T..T+33.
- **Fast path** (divide by zero, signed overflow): `o_Stall` is high in T only; `o_Done` is high in T+1.
- **Pipeline handshake**
  - The pipeline advances on the DONE-cycle edge.
  - The next divide can be accepted in the following IDLE cycle, T+35 at the earliest.
  - So back-to-back divides cost 35 cycles each.

## Structure
- Add to `def.v`:
  - `ALU_SEL_DIV` = 4'b1100, `ALU_SEL_REM` = 4'b1101.
  - FSM state encodings: IDLE 2'd0, CALC 2'd1, FIX 2'd2, DONE 2'd3.
- Sub-module `div_step`: combinational, one restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- The top level holds the FSM, counter, operand registers, and sign fix.

## Test plan
- **Signed DIV**: 100 / 7, start at T → `o_Result` = 14 with `o_Done` at T+34; `o_Stall` high exactly T..T+33.
- **Signed DIV and REM**: -100 / 7.
  - DIV → 0xFFFFFFF2.
  - REM → 0xFFFFFFFE.
  - REM of 100 by -7 → 2.
- **Divide by zero**: DIVU 0x12345678 / 0 → 0xFFFFFFFF and REMU → 0x12345678, each with `o_Done` at T+1.
- **Signed overflow**: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; `o_Done` at T+1.
- **Flush**: `i_Flush` at T+10 of DIVU 1000 / 3 → no `o_Done`, IDLE at T+11, `o_Result` keeps its old value. A new start at T+12 returns 333 at T+46.
- **Operand change and reset**
  - Operands change at T+5 of REMU 1000 / 3 → result is still 1.
  - `i_rst_n` low at T+20 → all outputs 0 and no `o_Done`.

Source files
------------

// File: rtl/rv32m_div_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: ALU select codes
// for the divide side of the decoder and the FSM state encoding.
package rv32m_div_unit_pkg;

  localparam logic [3:0] ALU_SEL_DIV = 4'b1100;  // return quotient
  localparam logic [3:0] ALU_SEL_REM = 4'b1101;  // return remainder

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/rv32m_div_unit_div_step.sv
// One radix-2 restoring division iteration. The partial remainder is shifted
// left with the next dividend bit appended and the divisor is trial-subtracted
// in XLEN+1 bits. Because the incoming remainder is always below the divisor,
// the difference fits a signed XLEN+1-bit value, so its top bit is the borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift, trial-subtract, and restore when the subtraction borrows.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage. Restoring
// division at one quotient bit per cycle, with single-cycle fast paths for
// divide-by-zero and signed overflow. Holds the pipeline via o_Stall until
// the registered result is presented alongside a one-cycle o_Done pulse.
module rv32m_div_unit
  import rv32m_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ctrl_Start_Div,
  input  logic            i_ctrl_Unsigned,
  input  logic [3:0]      i_ctrl_ALU_Sel,
  input  logic [XLEN-1:0] i_Operand_A,
  input  logic [XLEN-1:0] i_Operand_B,
  input  logic            i_Flush,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Done,
  output logic            o_Stall
);

  localparam int               CW      = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nxt;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            neg_q_q, neg_r_q, sel_rem_q;

  // Request decode and operand preparation, valid only in the accept cycle.
  logic            accept, is_signed, sign_a, sign_b, div_zero, overflow, fast;
  logic            sel_rem;
  logic [XLEN-1:0] abs_a, abs_b, fast_result;

  assign accept    = (state == ST_IDLE) && i_ctrl_Start_Div && !i_Flush;
  assign is_signed = !i_ctrl_Unsigned;
  assign sign_a    = is_signed && i_Operand_A[XLEN-1];
  assign sign_b    = is_signed && i_Operand_B[XLEN-1];
  assign abs_a     = sign_a ? -i_Operand_A : i_Operand_A;
  assign abs_b     = sign_b ? -i_Operand_B : i_Operand_B;
  assign div_zero  = (i_Operand_B == '0);
  assign overflow  = is_signed && (i_Operand_A == MIN_NEG) && (i_Operand_B == '1);
  assign fast      = div_zero || overflow;
  assign sel_rem   = (i_ctrl_ALU_Sel == ALU_SEL_REM);

  // Architectural results of the two special cases, which skip iteration.
  always_comb begin
    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    fast_result = '0;
    if (div_zero) fast_result = sel_rem ? i_Operand_A : '1;
    else          fast_result = sel_rem ? '0 : MIN_NEG;
  end

  // Single restoring iteration on the live {remainder, quotient} pair.
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[XLEN-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign correction applied to the magnitudes once iteration is complete.
  logic [XLEN-1:0] q_fixed, r_fixed;
  assign q_fixed = neg_q_q ? -quo_q : quo_q;
  assign r_fixed = neg_r_q ? -rem_q : rem_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a flush overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (count == LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (i_Flush) state_nxt = ST_IDLE;
  end

  // Datapath: latch on accept, iterate in CALC, load the result in FIX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      o_Result  <= '0;
    end else if (accept) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= abs_a;
      dvsr_q    <= abs_b;
      neg_q_q   <= sign_a ^ sign_b;
      neg_r_q   <= sign_a;
      sel_rem_q <= sel_rem;
      if (fast) o_Result <= fast_result;
    end else if (!i_Flush && state == ST_CALC) begin
      rem_q <= step_rem;
      quo_q <= {quo_q[XLEN-2:0], step_q};
      count <= count + CW'(1);
    end else if (!i_Flush && state == ST_FIX) begin
      o_Result <= sel_rem_q ? r_fixed : q_fixed;
    end
  end

  assign o_Done  = (state == ST_DONE);
  assign o_Stall = accept || (state == ST_CALC) || (state == ST_FIX);

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Self-checking bench for rv32m_div_unit: directed cases from the divide
// rules, random operands against a plain-arithmetic reference model, flush,
// operand changes, back-to-back issue and mid-operation reset.
module tb_rv32m_div_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        uns = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  sel = 4'b1100;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        done, stall;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  rv32m_div_unit #(.XLEN(XLEN)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ctrl_Start_Div (start),
    .i_ctrl_Unsigned  (uns),
    .i_ctrl_ALU_Sel   (sel),
    .i_Operand_A      (a),
    .i_Operand_B      (b),
    .i_Flush          (flush),
    .o_Result         (result),
    .o_Done           (done),
    .o_Stall          (stall)
  );

  // RISC-V M-extension semantics expressed with ordinary integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                            input bit is_uns, input bit is_rem);
    int sx, sy;
    if (y == 32'd0) return is_rem ? x : 32'hFFFF_FFFF;
    if (is_uns) return is_rem ? (x % y) : (x / y);
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
    sx = x;
    sy = y;
    return is_rem ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic bit is_fast(input logic [31:0] x, input logic [31:0] y, input bit is_uns);
    return (y == 32'd0) || (!is_uns && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // Issue one request at the current cycle (T = 0) and hold it until o_Done;
  // reports the done cycle, the stall profile and whether o_Done lingered.
  // Entered and left just after a rising edge.
  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, input bit tuns,
                         input bit trem, input int chg_at,
                         output logic [31:0] res, output int done_at, output int stall_cnt,
                         output int stall_last, output bit done_after);
    res = 'x; done_at = -1; stall_cnt = 0; stall_last = -1; done_after = 1'b0;
    a = ta; b = tb_v; uns = tuns; sel = trem ? 4'b1101 : 4'b1100; start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c == chg_at) begin
        a = $urandom; b = $urandom; uns = ~uns; sel = sel ^ 4'b0001;
      end
      @(negedge clk);
      if (stall) begin stall_cnt++; stall_last = c; end
      if (done) begin done_at = c; res = result; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    done_after = done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (done !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got done=%b stall=%b want 0/0", done, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_div();
    logic [31:0] r; int da, sc, sl; bit dn;
    run_div(32'd100, 32'd7, 1'b0, 1'b0, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL div_100_7: got %h want %h", r, 32'd14); end
    total++; if (da != 34) begin bad++; $display("FAIL div_latency: got %0d want 34", da); end
    total++; if (sc != 34) begin bad++; $display("FAIL div_stall_cycles: got %0d want 34", sc); end
    total++; if (sl != 33) begin bad++; $display("FAIL div_stall_last: got %0d want 33", sl); end
    total++; if (dn !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", dn); end
    last_res = 32'd14;
  endtask

  task automatic test_signed_rem();
    logic [31:0] r; int da, sc, sl; bit dn;
    run_div(-32'sd100, 32'd7, 1'b0, 1'b0, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL div_m100_7: got %h want %h", r, 32'hFFFF_FFF2); end
    run_div(-32'sd100, 32'd7, 1'b0, 1'b1, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rem_m100_7: got %h want %h", r, 32'hFFFF_FFFE); end
    total++; if (da != 34) begin bad++; $display("FAIL rem_latency: got %0d want 34", da); end
    run_div(32'd100, -32'sd7, 1'b0, 1'b1, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL rem_100_m7: got %h want %h", r, 32'd2); end
    last_res = 32'd2;
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int da, sc, sl; bit dn;
    run_div(32'h1234_5678, 32'd0, 1'b1, 1'b0, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by_zero: got %h want %h", r, 32'hFFFF_FFFF); end
    total++; if (da != 1) begin bad++; $display("FAIL divz_latency: got %0d want 1", da); end
    total++; if (sc != 1) begin bad++; $display("FAIL divz_stall_cycles: got %0d want 1", sc); end
    run_div(32'h1234_5678, 32'd0, 1'b1, 1'b1, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL remu_by_zero: got %h want %h", r, 32'h1234_5678); end
    total++; if (da != 1) begin bad++; $display("FAIL remz_latency: got %0d want 1", da); end
    last_res = 32'h1234_5678;
  endtask

  task automatic test_overflow();
    logic [31:0] r; int da, sc, sl; bit dn;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL ovf_div: got %h want %h", r, 32'h8000_0000); end
    total++; if (da != 1) begin bad++; $display("FAIL ovf_latency: got %0d want 1", da); end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL ovf_rem: got %h want %h", r, 32'h0); end
    total++; if (da != 1) begin bad++; $display("FAIL ovf_rem_latency: got %0d want 1", da); end
    last_res = 32'h0;
  endtask

  task automatic test_flush();
    logic [31:0] hold; logic [31:0] r; int da, sc, sl; bit dn; bit saw_done;
    hold = last_res; saw_done = 1'b0;
    a = 32'd1000; b = 32'd3; uns = 1'b1; sel = 4'b1100; start = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) flush = 1'b1;
      if (c == 11) begin flush = 1'b0; start = 1'b0; end
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (c == 11) begin
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: got %b want 0", stall); end
        total++; if (result !== hold) begin bad++; $display("FAIL flush_result_hold: got %h want %h", result, hold); end
      end
      @(posedge clk); #1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL flush_no_done: got %b want 0", saw_done); end
    run_div(32'd1000, 32'd3, 1'b1, 1'b0, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'd333) begin bad++; $display("FAIL after_flush_result: got %h want %h", r, 32'd333); end
    total++; if (da != 34) begin bad++; $display("FAIL after_flush_latency: got %0d want 34", da); end
    last_res = 32'd333;
  endtask

  task automatic test_operand_change();
    logic [31:0] r; int da, sc, sl; bit dn;
    run_div(32'd1000, 32'd3, 1'b1, 1'b1, 5, r, da, sc, sl, dn);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL operand_change: got %h want %h", r, 32'd1); end
    total++; if (da != 34) begin bad++; $display("FAIL operand_change_latency: got %0d want 34", da); end
    last_res = 32'd1;
  endtask

  task automatic test_random();
    logic [31:0] x, y, exp, r; bit tu, tr; int kind, da, sc, sl; bit dn;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      x = $urandom; y = $urandom;
      tu = 1'($urandom_range(0, 1)); tr = 1'($urandom_range(0, 1));
      if (kind == 0) y = 32'd0;
      else if (kind == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (kind == 2) begin x = 32'($signed(8'($urandom))); y = 32'($signed(4'($urandom))); end
      exp = ref_model(x, y, tu, tr);
      run_div(x, y, tu, tr, -1, r, da, sc, sl, dn);
      total++;
      if (r !== exp) begin
        bad++;
        $display("FAIL random_%0d: a=%h b=%h uns=%b rem=%b got %h want %h", i, x, y, tu, tr, r, exp);
      end
      total++;
      if (da != (is_fast(x, y, tu) ? 1 : 34)) begin
        bad++;
        $display("FAIL random_latency_%0d: got %0d want %0d", i, da, is_fast(x, y, tu) ? 1 : 34);
      end
      last_res = exp;
    end
  endtask

  task automatic test_back_to_back();
    int first, second; logic [31:0] r1, r2;
    first = -1; second = -1; r1 = 'x; r2 = 'x;
    a = 32'd100; b = 32'd7; uns = 1'b0; sel = 4'b1100; start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) begin first = c; r1 = result; end
        else begin second = c; r2 = result; break; end
      end
      @(posedge clk); #1;
      if (c == first) begin a = 32'd1000; b = 32'd3; uns = 1'b1; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (first != 34) begin bad++; $display("FAIL b2b_first_done: got %0d want 34", first); end
    total++; if (second != 69) begin bad++; $display("FAIL b2b_second_done: got %0d want 69", second); end
    total++; if (r1 !== 32'd14) begin bad++; $display("FAIL b2b_first_result: got %h want %h", r1, 32'd14); end
    total++; if (r2 !== 32'd333) begin bad++; $display("FAIL b2b_second_result: got %h want %h", r2, 32'd333); end
    @(posedge clk); #1;
    last_res = 32'd333;
  endtask

  task automatic test_reset_mid();
    bit saw_done; logic [31:0] r; int da, sc, sl; bit dn;
    saw_done = 1'b0;
    a = 32'd1000; b = 32'd3; uns = 1'b1; sel = 4'b1101; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result: got %h want %h", result, 32'h0); end
    total++; if (done !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL midreset_ctrl: got done=%b stall=%b want 0/0", done, stall); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done: got %b want 0", saw_done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result_hold: got %h want %h", result, 32'h0); end
    run_div(32'd1000, 32'd3, 1'b1, 1'b1, -1, r, da, sc, sl, dn);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL after_reset_result: got %h want %h", r, 32'd1); end
  endtask

  initial begin
    test_reset();
    test_signed_div();
    test_signed_rem();
    test_div_zero();
    test_overflow();
    test_flush();
    test_operand_change();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
